uart_frame_arbiter: RTL and testbench
=====================================

Name: uart_frame_arbiter

Overview:
- Shares the single 320-bit UART frame sender (send / data / send_done handshake) among NREQ on-chip requesters, e.g. key scanner, note logger and debug dumper.
- Round-robin arbitration; the granted frame is latched so requesters may change data once acked.
- The send strobe is held until send_done, then dropped for a guard gap so the sender sees a clean low.
- A watchdog aborts a transfer that never completes.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 320, frame width in bits; matches sender data port.
- GAP_CYC, 2, cycles send is held low after each transfer (≥1).
- TIMEOUT, 2000000, max cycles in SEND before abort (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  level request per requester; held with req_data until ack.
- req_data  in  NREQ*DATA_W  frame of requester i at bits [i*DATA_W +: DATA_W].
- ack  out  NREQ  one-cycle pulse to requester i when its frame completed.
- err  out  1  one-cycle pulse on watchdog abort.
- grant_id  out  $clog2(NREQ)  index of current/last granted requester.
- busy  out  1  high in any state except IDLE.
- send  out  1  strobe to frame sender; registered.
- data  out  DATA_W  latched frame to sender; registered.
- send_done  in  1  sender completion, sampled synchronously.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer = NREQ-1 so requester 0 wins first, gap and watchdog counters 0.
- Reset asserted mid-transfer: send drops asynchronously, no ack or err, and the pending frame is lost.
- FSM has three states:
  - IDLE: send=0. If |req, choose the first set bit scanning from ptr+1 modulo NREQ; register grant_id, data <= slice, send <= 1, ptr <= winner, go to SEND. Latency is 1 cycle from req sampled high to send=1 with data valid in the same cycle.
  - SEND: send=1, data stable, watchdog increments each cycle.
    - send_done=1: send<=0, ack[grant_id]<=1 for one cycle, go to GAP.
    - Watchdog reaches TIMEOUT-1 with send_done=0: send<=0, err<=1 for one cycle, no ack, go to GAP.
    - send_done and timeout in the same cycle: send_done wins (ack, no err).
    - req changes in SEND are ignored; the latched data is not affected.
  - GAP: send=0, counts GAP_CYC cycles, then goes to IDLE. Counter and watchdog are cleared on exit.
- send_done in IDLE or GAP is ignored.
- req is level-sensitive. A requester still asserting req when the FSM re-enters IDLE is treated as a new frame. Requesters must drop req within GAP_CYC cycles of ack to avoid a resend.
- Aborted requester: its req stays high, and it is retried only when round-robin reaches it again (fairness is preserved).
- Fairness: with all req high, grants go 0,1,2,3,0,... A single requester is re-granted back-to-back, each GAP_CYC+1 cycles after ack.
- Watchdog width is $clog2(TIMEOUT); the counter saturates and does not wrap.
- grant_id holds its value after a transfer until the next grant.

Decomposition:
- Shared package uart_pkg holds DATA_W=320, state encoding (IDLE=0, SEND=1, GAP=2) and the default TIMEOUT/GAP_CYC constants.
- One sub-module rr_picker (combinational plus no state: req, ptr -> winner one-hot/index, any) keeps the arbitration scan separate from the FSM.
- Counters stay in the top.

Test Plan:
- Single requester: reset, req=4'b0001, req_data[0]=all-ones. Expect send=1 one cycle later with data=all-ones. Drive send_done=1 after 10 cycles; expect ack=4'b0001 for one cycle, send=0 for ≥2 cycles, busy low after the gap.
- Round-robin: req=4'b1111 held, send_done returned 5 cycles after each send rise. Expect grant_id sequence 0,1,2,3,0 and data matching each slice (frame i = 320'd(i+1)).
- Timeout: TIMEOUT=16, req=4'b0100, send_done never asserted. Expect send high for exactly 16 cycles, err pulse, no ack, then re-grant of 2 after the gap.
- Simultaneous: send_done asserted on the same cycle the watchdog hits TIMEOUT-1. Expect ack pulse, err=0.
- Data isolation: change req_data[1] while requester 1 is in SEND. Expect data unchanged until send_done.
- Reset mid-send: assert rst during SEND. Expect send=0, ack=0, busy=0 immediately. After release with req=4'b1010, first grant goes to requester 1 (ptr reset).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame arbiter.
//   UART_DATA_W  : width of one frame, matching the frame sender data port
//   GAP_CYC_DEF  : default number of cycles send stays low after a transfer
//   TIMEOUT_DEF  : default watchdog limit (cycles in SEND before abort)
//   state_t      : arbiter FSM state encoding
package uart_pkg;

   localparam int UART_DATA_W = 320;
   localparam int GAP_CYC_DEF = 2;
   localparam int TIMEOUT_DEF = 2000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection, purely combinational.
//   req        : request vector, one bit per requester
//   ptr        : index of the last winner; scanning starts at ptr+1 mod NREQ
//   winner_oh  : one-hot of the chosen requester (all zero when none)
//   winner_idx : index of the chosen requester (zero when none)
//   any        : at least one request is pending
module rr_picker #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  winner_oh,
   output logic [IDX_W-1:0] winner_idx,
   output logic             any
);

   always_comb begin
      logic found;
      int   idx;
      found      = 1'b0;
      idx        = 0;
      winner_oh  = '0;
      winner_idx = '0;
      any        = |req;
      // Offsets 1..NREQ visit every requester once, the previous winner last.
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found          = 1'b1;
            winner_oh[idx] = 1'b1;
            winner_idx     = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Shares one UART frame sender among NREQ requesters with round-robin
// arbitration, a latched frame, a post-transfer guard gap and a watchdog.
//   clk, rst   : clock and asynchronous active-high reset
//   req        : level request per requester, held until ack
//   req_data   : frame of requester i at [i*DATA_W +: DATA_W]
//   ack        : one-cycle pulse to the requester whose frame completed
//   err        : one-cycle pulse when the watchdog aborts a transfer
//   grant_id   : index of the current / last granted requester
//   busy       : FSM is not in IDLE
//   send, data : registered strobe and latched frame to the sender
//   send_done  : sender completion, sampled synchronously
module uart_frame_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DATA_W  = UART_DATA_W,
   parameter int GAP_CYC = GAP_CYC_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          ack,
   output logic                     err,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy,
   output logic                     send,
   output logic [DATA_W-1:0]        data,
   input  logic                     send_done
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam int GAP_W = $clog2(GAP_CYC + 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                send_q, send_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic                err_q, err_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [GAP_W-1:0]    gap_q, gap_d;

   logic [NREQ-1:0]     win_oh;
   logic [IDX_W-1:0]    win_idx;
   logic                win_any;
   logic [DATA_W-1:0]   win_data;
   logic [DATA_W-1:0]   slice_masked [NREQ];

   rr_picker #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req        (req),
      .ptr        (ptr_q),
      .winner_oh  (win_oh),
      .winner_idx (win_idx),
      .any        (win_any)
   );

   // AND-OR mux on the one-hot winner: avoids a wide variable part-select.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice_masked[gi] = req_data[gi*DATA_W +: DATA_W] & {DATA_W{win_oh[gi]}};
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         win_data = win_data | slice_masked[i];
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      send_d  = send_q;
      ack_d   = '0;
      err_d   = 1'b0;
      wd_d    = wd_q;
      gap_d   = gap_q;

      unique case (state_q)
         IDLE: begin
            send_d = 1'b0;
            if (win_any) begin
               grant_d = win_idx;
               data_d  = win_data;
               send_d  = 1'b1;
               ptr_d   = win_idx;
               state_d = SEND;
            end
         end
         SEND: begin
            // send_done has priority over a simultaneous timeout.
            if (send_done) begin
               send_d         = 1'b0;
               ack_d[grant_q] = 1'b1;
               state_d        = GAP;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               send_d  = 1'b0;
               err_d   = 1'b1;
               state_d = GAP;
            end else if (wd_q != {WD_W{1'b1}}) begin
               wd_d = wd_q + 1'b1;
            end
         end
         GAP: begin
            send_d = 1'b0;
            if (gap_q == GAP_W'(GAP_CYC - 1)) begin
               gap_d   = '0;
               wd_d    = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            send_d  = 1'b0;
            gap_d   = '0;
            wd_d    = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IDX_W'(NREQ - 1);   // requester 0 wins first
         grant_q <= '0;
         data_q  <= '0;
         send_q  <= 1'b0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         wd_q    <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         send_q  <= send_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
         gap_q   <= gap_d;
      end
   end

   assign ack      = ack_q;
   assign err      = err_q;
   assign grant_id = grant_q;
   assign busy     = (state_q != IDLE);
   assign send     = send_q;
   assign data     = data_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
module tb_uart_frame_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 320;
   localparam int GAPC = 2;
   localparam int TO   = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      ack;
   logic                 err;
   logic [1:0]           grant_id;
   logic                 busy;
   logic                 send;
   logic [DW-1:0]        data;
   logic                 send_done;

   int checks = 0;
   int errors = 0;

   typedef enum int {EV_GRANT, EV_ACK, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t      kind;
      logic [1:0]    gid;
      logic [DW-1:0] fdata;
      logic [3:0]    ackv;
   } ev_t;

   ev_t exp_q[$];

   uart_frame_arbiter #(
      .NREQ    (NREQ),
      .DATA_W  (DW),
      .GAP_CYC (GAPC),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .err       (err),
      .grant_id  (grant_id),
      .busy      (busy),
      .send      (send),
      .data      (data),
      .send_done (send_done)
   );

   always #5 clk = ~clk;

   // ---------------- expectation helpers ----------------
   function automatic void push_grant(input int id, input logic [DW-1:0] d);
      ev_t e;
      e.kind = EV_GRANT; e.gid = 2'(id); e.fdata = d; e.ackv = '0;
      exp_q.push_back(e);
   endfunction

   function automatic void push_ack(input int id);
      ev_t e;
      e.kind = EV_ACK; e.gid = 2'(id); e.fdata = '0; e.ackv = 4'b0001 << id;
      exp_q.push_back(e);
   endfunction

   function automatic void push_err();
      ev_t e;
      e.kind = EV_ERR; e.gid = '0; e.fdata = '0; e.ackv = '0;
      exp_q.push_back(e);
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic send_prev = 1'b0;

   task automatic observe(input ev_kind_t k, input string nm);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected event ack=%b err=%b grant_id=%0d", nm, ack, err, grant_id);
         return;
      end
      e = exp_q.pop_front();
      case (k)
         EV_GRANT: begin
            if (e.kind != EV_GRANT || grant_id != e.gid || data != e.fdata) begin
               errors++;
               $display("FAIL %s got grant_id=%0d data=%h expected kind=%0d grant_id=%0d data=%h",
                        nm, grant_id, data, e.kind, e.gid, e.fdata);
            end else
               $display("grant id=%0d data[31:0]=%h", grant_id, data[31:0]);
         end
         EV_ACK: begin
            if (e.kind != EV_ACK || ack != e.ackv) begin
               errors++;
               $display("FAIL %s got ack=%b expected kind=%0d ack=%b", nm, ack, e.kind, e.ackv);
            end else
               $display("ack %b", ack);
         end
         default: begin
            if (e.kind != EV_ERR) begin
               errors++;
               $display("FAIL %s got err=1 expected kind=%0d", nm, e.kind);
            end else
               $display("err pulse grant_id=%0d", grant_id);
         end
      endcase
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ack != '0)          observe(EV_ACK, "ack_event");
         if (err)                observe(EV_ERR, "err_event");
         if (send && !send_prev) observe(EV_GRANT, "grant_event");
      end
      send_prev = send;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   task automatic wait_send(input string nm);
      int b;
      b = 0;
      while (!send && b < 50) begin
         step(1);
         b++;
      end
      checks++;
      if (!send) begin
         errors++;
         $display("FAIL %s send=%b required=1 within 50 cycles", nm, send);
      end
   endtask

   // Called right after send rose; send_done is sampled d cycles after the rise.
   // Returns in the cycle where ack is visible.
   task automatic finish_frame(input int d);
      step(d - 1);
      send_done = 1'b1;
      step(1);
      send_done = 1'b0;
   endtask

   function automatic void set_slice(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [DW-1:0] ones, pat_a, pat_b, pat_c, pat_d, pat_t;
      int cnt;
      ones  = {DW{1'b1}};
      pat_a = {10{32'hA5A5_0001}};
      pat_b = {10{32'h5A5A_FFFE}};
      pat_c = {10{32'hC0DE_1111}};
      pat_d = {10{32'hD00D_3333}};
      pat_t = {10{32'h1234_5678}};

      rst = 1'b1; req = '0; req_data = '0; send_done = 1'b0;
      step(2);
      // Reset state
      chk("rst_send",  DW'(send), '0);
      chk("rst_ack",   DW'(ack), '0);
      chk("rst_err",   DW'(err), '0);
      chk("rst_busy",  DW'(busy), '0);
      chk("rst_gid",   DW'(grant_id), '0);
      chk("rst_data",  data, '0);
      rst = 1'b0;
      step(1);

      // Single requester, all-ones frame
      push_grant(0, ones); push_ack(0);
      set_slice(0, ones); req = 4'b0001;
      step(1);
      chk("t1_latency_send", DW'(send), DW'(1));
      chk("t1_busy", DW'(busy), DW'(1));
      finish_frame(10);
      req = '0;
      chk("t1_send_low0", DW'(send), '0);
      step(1);
      chk("t1_send_low1", DW'(send), '0);
      chk("t1_busy_gap", DW'(busy), DW'(1));
      step(1);
      chk("t1_busy_idle", DW'(busy), '0);
      step(3);

      // Round-robin with all requesters active
      do_reset();
      for (int i = 0; i < NREQ; i++) set_slice(i, DW'(i + 1));
      push_grant(0, DW'(1)); push_ack(0);
      push_grant(1, DW'(2)); push_ack(1);
      push_grant(2, DW'(3)); push_ack(2);
      push_grant(3, DW'(4)); push_ack(3);
      push_grant(0, DW'(1)); push_ack(0);
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_send("t2_wait");
         finish_frame(5);
      end
      req = '0;
      step(5);

      // Watchdog abort, then retry of the same requester
      do_reset();
      set_slice(2, pat_t);
      push_grant(2, pat_t); push_err(); push_grant(2, pat_t); push_ack(2);
      req = 4'b0100;
      wait_send("t3_wait");
      cnt = 0;
      while (send && cnt < 100) begin
         cnt++;
         step(1);
      end
      chk("t3_send_cycles", DW'(cnt), DW'(TO));
      chk("t3_no_ack", DW'(ack), '0);
      step(2);
      chk("t3_gap_send_low", DW'(send), '0);
      step(1);
      chk("t3_regrant", DW'(send), DW'(1));
      finish_frame(2);
      req = '0;
      step(5);

      // send_done on the same cycle the watchdog expires
      do_reset();
      set_slice(0, pat_a);
      push_grant(0, pat_a); push_ack(0);
      req = 4'b0001;
      wait_send("t4_wait");
      finish_frame(TO);
      req = '0;
      chk("t4_err_low", DW'(err), '0);
      chk("t4_ack", DW'(ack), DW'(4'b0001));
      step(5);

      // Latched frame unaffected by req / req_data changes during SEND
      do_reset();
      set_slice(1, pat_a);
      push_grant(1, pat_a); push_ack(1);
      req = 4'b0010;
      wait_send("t5_wait");
      step(1);
      set_slice(1, pat_b);
      req = 4'b0011;
      step(3);
      chk("t5_data_held", data, pat_a);
      chk("t5_gid_held", DW'(grant_id), DW'(1));
      send_done = 1'b1;
      step(1);
      send_done = 1'b0;
      req = '0;
      step(5);

      // Reset in the middle of a transfer
      do_reset();
      set_slice(0, pat_d);
      push_grant(0, pat_d);
      req = 4'b0001;
      wait_send("t6_wait");
      step(2);
      rst = 1'b1;
      #1;
      chk("t6_rst_send", DW'(send), '0);
      chk("t6_rst_ack", DW'(ack), '0);
      chk("t6_rst_busy", DW'(busy), '0);
      set_slice(1, pat_c); set_slice(3, pat_b);
      req = 4'b1010;
      push_grant(1, pat_c); push_ack(1);
      step(1);
      rst = 1'b0;
      wait_send("t6_wait2");
      finish_frame(3);
      req = '0;
      step(10);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events remaining=%0d required=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
